// File: rtl/palette_host_writer.sv
// Palette host writer: turns single-entry write/read and whole-palette fill
// commands into byte-wide accesses on the host memory port. Each 16-bit
// palette entry occupies two consecutive host bytes, low byte first.
module palette_host_writer #(
    parameter logic [19:0] TXT_PALETTE_ADDR = 20'h04000,
    parameter logic [19:0] GFX_PALETTE_ADDR = 20'h04200,
    parameter int          READ_LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic        cmd_sel,
    input  logic [7:0]  cmd_index,
    input  logic [15:0] cmd_color,
    output logic        rsp_valid,
    output logic [15:0] rsp_color,
    output logic        busy,
    output logic        host_wrena,
    output logic [19:0] host_addr_out,
    output logic [7:0]  host_data_out,
    input  logic [7:0]  host_data_in
);

    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WR_HI,
        RD_LO,
        RD_HI,
        RD_WAIT,
        RESP
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_FILL  = 2'd2;

    // Remaining RD_WAIT clocks after RD_HI; the high byte lands when it hits 0.
    localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);

    state_t      state_reg;
    logic        sel_reg;
    logic        fill_reg;
    logic [7:0]  index_reg;
    logic [15:0] color_reg;
    logic [7:0]  lo_reg;
    logic [1:0]  wait_cnt_reg;

    logic [19:0] cmd_base;
    logic [19:0] cur_base;
    logic [7:0]  index_next;

    // Byte address of one half of an entry; full 20-bit sum so index 255
    // high byte lands on base + 0x1FF and never aliases elsewhere.
    function automatic logic [19:0] entry_addr(input logic [19:0] base,
                                               input logic [7:0]  idx,
                                               input logic        hi);
        return base + {11'd0, idx, hi};
    endfunction

    // Palette base for the incoming command and for the latched command.
    always_comb begin
        cmd_base   = cmd_sel ? GFX_PALETTE_ADDR : TXT_PALETTE_ADDR;
        cur_base   = sel_reg ? GFX_PALETTE_ADDR : TXT_PALETTE_ADDR;
        index_next = index_reg + 8'd1;
    end

    // Command FSM with all host-side and response outputs registered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            sel_reg       <= 1'b0;
            fill_reg      <= 1'b0;
            index_reg     <= 8'd0;
            color_reg     <= 16'd0;
            lo_reg        <= 8'd0;
            wait_cnt_reg  <= 2'd0;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_color     <= 16'd0;
            busy          <= 1'b0;
            host_wrena    <= 1'b0;
            host_addr_out <= 20'd0;
            host_data_out <= 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cmd_ready     <= 1'b1;
                    busy          <= 1'b0;
                    rsp_valid     <= 1'b0;
                    host_wrena    <= 1'b0;
                    host_data_out <= 8'd0;
                    if (cmd_valid && cmd_ready) begin
                        sel_reg   <= cmd_sel;
                        color_reg <= cmd_color;
                        case (cmd_op)
                            OP_WRITE: begin
                                state_reg     <= WR_LO;
                                cmd_ready     <= 1'b0;
                                busy          <= 1'b1;
                                fill_reg      <= 1'b0;
                                index_reg     <= cmd_index;
                                host_wrena    <= 1'b1;
                                host_addr_out <= entry_addr(cmd_base, cmd_index, 1'b0);
                                host_data_out <= cmd_color[7:0];
                            end
                            OP_READ: begin
                                state_reg     <= RD_LO;
                                cmd_ready     <= 1'b0;
                                busy          <= 1'b1;
                                fill_reg      <= 1'b0;
                                index_reg     <= cmd_index;
                                host_addr_out <= entry_addr(cmd_base, cmd_index, 1'b0);
                            end
                            OP_FILL: begin
                                // Fill always sweeps the whole palette from entry 0.
                                state_reg     <= WR_LO;
                                cmd_ready     <= 1'b0;
                                busy          <= 1'b1;
                                fill_reg      <= 1'b1;
                                index_reg     <= 8'd0;
                                host_wrena    <= 1'b1;
                                host_addr_out <= entry_addr(cmd_base, 8'd0, 1'b0);
                                host_data_out <= cmd_color[7:0];
                            end
                            default: begin
                                // Reserved opcode: swallowed in the accepting clock.
                            end
                        endcase
                    end
                end

                WR_LO: begin
                    state_reg     <= WR_HI;
                    host_wrena    <= 1'b1;
                    host_addr_out <= entry_addr(cur_base, index_reg, 1'b1);
                    host_data_out <= color_reg[15:8];
                end

                WR_HI: begin
                    if (fill_reg && (index_reg != 8'hFF)) begin
                        // Next fill entry follows with no idle clock.
                        state_reg     <= WR_LO;
                        index_reg     <= index_next;
                        host_wrena    <= 1'b1;
                        host_addr_out <= entry_addr(cur_base, index_next, 1'b0);
                        host_data_out <= color_reg[7:0];
                    end else begin
                        // Single write done, or fill counter wraps 255->0.
                        state_reg     <= IDLE;
                        index_reg     <= index_next;
                        fill_reg      <= 1'b0;
                        cmd_ready     <= 1'b1;
                        busy          <= 1'b0;
                        host_wrena    <= 1'b0;
                        host_data_out <= 8'd0;
                    end
                end

                RD_LO: begin
                    state_reg     <= RD_HI;
                    host_addr_out <= entry_addr(cur_base, index_reg, 1'b1);
                end

                RD_HI: begin
                    // With a one-clock host latency the low byte is already back.
                    if (READ_LATENCY == 1) begin
                        lo_reg <= host_data_in;
                    end
                    wait_cnt_reg <= WAIT_INIT;
                    state_reg    <= RD_WAIT;
                end

                RD_WAIT: begin
                    if (wait_cnt_reg == 2'd1) begin
                        lo_reg <= host_data_in;
                    end
                    if (wait_cnt_reg == 2'd0) begin
                        rsp_color <= {host_data_in, lo_reg};
                        rsp_valid <= 1'b1;
                        state_reg <= RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 2'd1;
                    end
                end

                RESP: begin
                    rsp_valid <= 1'b0;
                    state_reg <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end

                default: begin
                    state_reg  <= IDLE;
                    cmd_ready  <= 1'b1;
                    busy       <= 1'b0;
                    host_wrena <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_palette_host_writer.sv
// Bench for palette_host_writer: three instances at host read latencies
// 2, 1 and 4 share a host memory model. Stimulus pushes expected host
// writes, read addresses and responses into queues; monitors pop and compare.
module tb_palette_host_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [2:0]        cmd_valid_v;
    logic [1:0]        cmd_op;
    logic              cmd_sel;
    logic [7:0]        cmd_index;
    logic [15:0]       cmd_color;
    logic [2:0]        cmd_ready_v;
    logic [2:0]        rsp_valid_v;
    logic [2:0]        busy_v;
    logic [2:0]        wrena_v;
    logic [2:0][15:0]  rsp_color_p;
    logic [2:0][19:0]  haddr_p;
    logic [2:0][7:0]   hdout_p;
    logic [2:0][7:0]   hdin_p;

    logic [7:0] mem [0:1023];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct { int lane; logic [19:0] addr; logic [7:0] data; } wr_t;
    typedef struct { int lane; logic [15:0] color; } rsp_t;
    typedef struct { int lane; logic [19:0] addr; } ra_t;

    wr_t  wr_q[$];
    rsp_t rsp_q[$];
    ra_t  ra_q[$];

    logic [19:0] prev_addr [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);
            logic [19:0] pipe [4];

            palette_host_writer #(.READ_LATENCY(LAT)) u_dut (
                .clk           (clk),
                .reset_n       (reset_n),
                .cmd_valid     (cmd_valid_v[gi]),
                .cmd_ready     (cmd_ready_v[gi]),
                .cmd_op        (cmd_op),
                .cmd_sel       (cmd_sel),
                .cmd_index     (cmd_index),
                .cmd_color     (cmd_color),
                .rsp_valid     (rsp_valid_v[gi]),
                .rsp_color     (rsp_color_p[gi]),
                .busy          (busy_v[gi]),
                .host_wrena    (wrena_v[gi]),
                .host_addr_out (haddr_p[gi]),
                .host_data_out (hdout_p[gi]),
                .host_data_in  (hdin_p[gi])
            );

            // Host read model: data for an address appears LAT clocks later.
            always @(posedge clk) begin
                pipe[0] <= haddr_p[gi];
                for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
            end
            assign hdin_p[gi] = mem[pipe[LAT-1][9:0]];
        end
    endgenerate

    // Host memory only takes writes from lane 0.
    always @(posedge clk) begin
        if (wrena_v[0]) mem[haddr_p[0][9:0]] <= hdout_p[0];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_wr(input int lane, input logic [19:0] a, input logic [7:0] d);
        wr_t e;
        e.lane = lane; e.addr = a; e.data = d;
        wr_q.push_back(e);
    endtask

    task automatic push_rd(input int lane, input logic [19:0] lo_a, input logic [15:0] col);
        ra_t  a;
        rsp_t r;
        a.lane = lane; a.addr = lo_a;         ra_q.push_back(a);
        a.lane = lane; a.addr = lo_a + 20'd1; ra_q.push_back(a);
        r.lane = lane; r.color = col;         rsp_q.push_back(r);
    endtask

    // Called at a falling edge; returns the cycle stamp of the accepting clock.
    task automatic send(input int lane, input logic [1:0] op, input logic sel,
                        input logic [7:0] idx, input logic [15:0] col,
                        input bit hold, output int acc);
        cmd_op = op; cmd_sel = sel; cmd_index = idx; cmd_color = col;
        cmd_valid_v = 3'b000;
        cmd_valid_v[lane] = 1'b1;
        acc = -1;
        for (int t = 0; t < 2000; t++) begin
            if (cmd_ready_v[lane]) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout lane=%0d: got no cmd_ready, required cmd_ready", lane);
        end
        @(negedge clk);
        if (!hold) cmd_valid_v = 3'b000;
    endtask

    task automatic wait_ready(input int lane, input int acc, output int dt);
        dt = -1;
        for (int t = 0; t < 2000; t++) begin
            if (cmd_ready_v[lane]) begin
                dt = cyc - acc;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Write / data-out monitor.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (wrena_v[k]) begin
                n_checks++;
                if (wr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL host_write lane=%0d: got unexpected write addr=%h data=%h, required none",
                             k, haddr_p[k], hdout_p[k]);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    if (e.lane != k || e.addr !== haddr_p[k] || e.data !== hdout_p[k]) begin
                        n_fail++;
                        $display("FAIL host_write: got lane=%0d addr=%h data=%h required lane=%0d addr=%h data=%h",
                                 k, haddr_p[k], hdout_p[k], e.lane, e.addr, e.data);
                    end
                end
            end else begin
                n_checks++;
                if (hdout_p[k] !== 8'h00) begin
                    n_fail++;
                    $display("FAIL data_out_idle lane=%0d: got %h required 00", k, hdout_p[k]);
                end
            end
        end
    end

    // Read-address monitor: a new non-zero address without a write strobe.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!wrena_v[k] && haddr_p[k] !== prev_addr[k] && haddr_p[k] !== 20'd0) begin
                n_checks++;
                if (ra_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL read_addr lane=%0d: got unexpected addr=%h, required none", k, haddr_p[k]);
                end else begin
                    ra_t e;
                    e = ra_q.pop_front();
                    if (e.lane != k || e.addr !== haddr_p[k]) begin
                        n_fail++;
                        $display("FAIL read_addr: got lane=%0d addr=%h required lane=%0d addr=%h",
                                 k, haddr_p[k], e.lane, e.addr);
                    end
                end
            end
            prev_addr[k] <= haddr_p[k];
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rsp_valid_v[k]) begin
                n_checks++;
                if (rsp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp lane=%0d: got unexpected rsp_valid color=%h, required none", k, rsp_color_p[k]);
                end else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    if (e.lane != k || e.color !== rsp_color_p[k]) begin
                        n_fail++;
                        $display("FAIL rsp: got lane=%0d color=%h required lane=%0d color=%h",
                                 k, rsp_color_p[k], e.lane, e.color);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc_b, dt, bcnt, found;
        int exp_rd_dt [3];
        exp_rd_dt[0] = 6; exp_rd_dt[1] = 5; exp_rd_dt[2] = 8;

        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[10'h3FE] = 8'h34;
        mem[10'h3FF] = 8'h12;

        reset_n = 1'b0;
        cmd_valid_v = 3'b000;
        cmd_op = 2'd0; cmd_sel = 1'b0; cmd_index = 8'd0; cmd_color = 16'd0;
        repeat (3) @(negedge clk);

        chk("reset_cmd_ready", 32'(cmd_ready_v[0]), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid_v[0]), 32'd0);
        chk("reset_rsp_color", 32'(rsp_color_p[0]), 32'd0);
        chk("reset_busy",      32'(busy_v[0]),      32'd0);
        chk("reset_wrena",     32'(wrena_v[0]),     32'd0);
        chk("reset_addr",      32'(haddr_p[0]),     32'd0);
        chk("reset_data",      32'(hdout_p[0]),     32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(cmd_ready_v[0]), 32'd1);

        // Single write: text palette, index 0x12, colour 0xA5C3.
        push_wr(0, 20'h04024, 8'hC3);
        push_wr(0, 20'h04025, 8'hA5);
        send(0, 2'd0, 1'b0, 8'h12, 16'hA5C3, 1'b0, acc);
        $display("txn write sel=0 idx=12 color=a5c3 accepted at cycle %0d", acc);
        wait_ready(0, acc, dt);
        chk("write_ready_latency", 32'(dt), 32'd3);

        // Read back the entry just written.
        push_rd(0, 20'h04024, 16'hA5C3);
        send(0, 2'd1, 1'b0, 8'h12, 16'h0000, 1'b0, acc);
        $display("txn read sel=0 idx=12 lane=0 accepted at cycle %0d", acc);
        wait_ready(0, acc, dt);
        chk("readback_ready_latency", 32'(dt), 32'd6);

        // Graphics index 0xFF read at latencies 2, 1 and 4.
        for (int ln = 0; ln < 3; ln++) begin
            push_rd(ln, 20'h043FE, 16'h1234);
            send(ln, 2'd1, 1'b1, 8'hFF, 16'h0000, 1'b0, acc);
            $display("txn read sel=1 idx=ff lane=%0d accepted at cycle %0d", ln, acc);
            wait_ready(ln, acc, dt);
            chk("read_ready_latency", 32'(dt), 32'(exp_rd_dt[ln]));
            repeat (3) @(negedge clk);
            chk("rsp_color_hold", 32'(rsp_color_p[ln]), 32'h1234);
        end

        // Back-to-back commands with cmd_valid held high.
        push_wr(0, 20'h04002, 8'h11);
        push_wr(0, 20'h04003, 8'h22);
        push_wr(0, 20'h04204, 8'h33);
        push_wr(0, 20'h04205, 8'h44);
        send(0, 2'd0, 1'b0, 8'h01, 16'h2211, 1'b1, acc);
        send(0, 2'd0, 1'b1, 8'h02, 16'h4433, 1'b0, acc_b);
        $display("txn held write pair accepted at cycles %0d and %0d", acc, acc_b);
        chk("held_second_accept_gap", 32'(acc_b - acc), 32'd3);
        wait_ready(0, acc_b, dt);
        chk("held_second_ready_latency", 32'(dt), 32'd3);

        // Fill graphics palette with 0xF800.
        for (int i = 0; i < 256; i++) begin
            push_wr(0, 20'h04200 + 20'(2 * i),     8'h00);
            push_wr(0, 20'h04200 + 20'(2 * i + 1), 8'hF8);
        end
        send(0, 2'd2, 1'b1, 8'h00, 16'hF800, 1'b0, acc);
        bcnt = 0;
        while (busy_v[0] && bcnt < 2000) begin
            bcnt++;
            @(negedge clk);
        end
        $display("txn fill sel=1 color=f800 busy for %0d clocks", bcnt);
        chk("fill_busy_clocks", 32'(bcnt), 32'd512);
        chk("fill_ready_after", 32'(cmd_ready_v[0]), 32'd1);
        chk("fill_writes_drained", 32'(wr_q.size()), 32'd0);

        // Read a filled entry.
        push_rd(0, 20'h04300, 16'hF800);
        send(0, 2'd1, 1'b1, 8'h80, 16'h0000, 1'b0, acc);
        $display("txn read sel=1 idx=80 after fill accepted at cycle %0d", acc);
        wait_ready(0, acc, dt);
        chk("fill_read_ready_latency", 32'(dt), 32'd6);

        // Reserved opcode.
        send(0, 2'd3, 1'b0, 8'h55, 16'h5555, 1'b0, acc);
        $display("txn reserved op accepted at cycle %0d", acc);
        chk("reserved_busy", 32'(busy_v[0]), 32'd0);
        wait_ready(0, acc, dt);
        chk("reserved_ready_latency", 32'(dt), 32'd1);

        // Fill text palette, reset at entry 100 low byte.
        for (int i = 0; i < 100; i++) begin
            push_wr(0, 20'h04000 + 20'(2 * i),     8'h3E);
            push_wr(0, 20'h04000 + 20'(2 * i + 1), 8'h9C);
        end
        push_wr(0, 20'h040C8, 8'h3E);
        send(0, 2'd2, 1'b0, 8'h00, 16'h9C3E, 1'b0, acc);
        found = 0;
        for (int t = 0; t < 2000; t++) begin
            if (wrena_v[0] && haddr_p[0] == 20'h040C8) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("fill_reached_entry_100", 32'(found), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        $display("txn reset asserted during fill at cycle %0d", cyc);
        chk("abort_wrena",     32'(wrena_v[0]),     32'd0);
        chk("abort_cmd_ready", 32'(cmd_ready_v[0]), 32'd0);
        chk("abort_busy",      32'(busy_v[0]),      32'd0);
        chk("abort_addr",      32'(haddr_p[0]),     32'd0);
        chk("abort_data",      32'(hdout_p[0]),     32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid_v[0]), 32'd0);
        chk("abort_rsp_color", 32'(rsp_color_p[0]), 32'd0);
        chk("abort_writes_drained", 32'(wr_q.size()), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Normal write after the aborted fill.
        push_wr(0, 20'h04006, 8'hEF);
        push_wr(0, 20'h04007, 8'hBE);
        send(0, 2'd0, 1'b0, 8'h03, 16'hBEEF, 1'b0, acc);
        $display("txn write sel=0 idx=03 color=beef accepted at cycle %0d", acc);
        wait_ready(0, acc, dt);
        chk("post_reset_write_latency", 32'(dt), 32'd3);

        repeat (5) @(negedge clk);
        chk("end_wr_queue_empty",  32'(wr_q.size()),  32'd0);
        chk("end_ra_queue_empty",  32'(ra_q.size()),  32'd0);
        chk("end_rsp_queue_empty", 32'(rsp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/palette_host_writer.md
PALETTE_HOST_WRITER -- requirements
Module: palette_host_writer

Interface
REQ-001 Parameter TXT_PALETTE_ADDR, default 20'h04000: byte base address of the text/sprite (4444) palette on the host port.
REQ-002 Parameter GFX_PALETTE_ADDR, default 20'h04200: byte base address of the graphics (565) palette on the host port.
REQ-003 Parameter READ_LATENCY, default 2, legal range 1-4: clocks from address presentation to valid host_data_in.
REQ-004 clk  in  1: single clock, all logic on rising edge.
REQ-005 reset_n  in  1: synchronous, active-low reset.
REQ-006 cmd_valid  in  1: command offered.
REQ-007 cmd_ready  out  1: command accepted when cmd_valid and cmd_ready are both high.
REQ-008 cmd_op  in  2: 0 = write entry, 1 = read entry, 2 = fill palette, 3 = reserved (ignored).
REQ-009 cmd_sel  in  1: 0 = text palette, 1 = graphics palette.
REQ-010 cmd_index  in  8: palette entry index.
REQ-011 cmd_color  in  16: colour word, 4444 or 565 packed.
REQ-012 rsp_valid  out  1: one-clock pulse, read data valid.
REQ-013 rsp_color  out  16: read-back colour word.
REQ-014 busy  out  1: high whenever the state is not IDLE.
REQ-015 host_wrena  out  1: byte write strobe to the palette host port.
REQ-016 host_addr_out  out  20: host byte address.
REQ-017 host_data_out  out  8: host write byte.
REQ-018 host_data_in  in  8: host read byte.

Function
REQ-019 Entry address: base + {cmd_index, b}, where b = 0 for the low byte [7:0] and b = 1 for the high byte [15:8]; the low byte is always issued first.
REQ-020 States: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RD_WAIT, RESP.
REQ-021 cmd_ready = 1 only in IDLE (registered); the command fields are latched on acceptance.
REQ-022 Write: IDLE->WR_LO->WR_HI->IDLE, with host_wrena = 1 for exactly one clock in each of WR_LO and WR_HI; cmd_ready returns high 3 clocks after acceptance.
REQ-023 Read: RD_LO presents the low address and RD_HI presents the high address, with host_wrena = 0 throughout.
REQ-024 Read: the low byte is captured READ_LATENCY clocks after RD_LO and the high byte READ_LATENCY clocks after RD_HI, with RD_WAIT counting down the remainder.
REQ-025 Read: in RESP, rsp_valid = 1 for one clock and rsp_color = {hi, lo}; rsp_color holds its value until the next read response.
REQ-026 Fill: write cmd_color to indices 0 to 255 of the selected palette, two byte writes per entry, back-to-back with no idle clocks (512 clocks total).
REQ-027 Fill: the 8-bit entry counter wraps 255->0 and terminates on the wrap; busy stays high throughout the fill.
REQ-028 cmd_op = 3 is consumed in one clock with no host activity.
REQ-029 host_addr_out is registered and holds its last value when idle; host_data_out = 0 whenever host_wrena = 0.
REQ-030 No wrap into the adjacent region: the address sum is 20 bits, and index 255 high byte = base + 0x1FF.
REQ-031 Commands offered while busy are not accepted and are not lost; they are held by the master until cmd_ready.

Reset
REQ-032 Reset values: state IDLE, cmd_ready = 0 during reset and 1 on the first clock after release.
REQ-033 Reset values: rsp_valid = 0, rsp_color = 0, busy = 0, host_wrena = 0, host_addr_out = 0, host_data_out = 0.
REQ-034 Reset asserted mid-write, mid-read or mid-fill aborts the operation at the next edge, with no further host_wrena and no rsp_valid.

Verification
REQ-035 Write sel=0, index=0x12, color=0xA5C3 -> host writes (0x04024, 0xC3) then (0x04025, 0xA5) on consecutive clocks; cmd_ready high 3 clocks after acceptance.
REQ-036 Read sel=1, index=0xFF, model returns 0x34 then 0x12 at READ_LATENCY=2 -> addresses 0x043FE then 0x043FF, rsp_valid single pulse, rsp_color = 0x1234; repeat at READ_LATENCY = 1 and 4.
REQ-037 Fill sel=1, color=0xF800 -> exactly 512 writes covering 0x04200-0x043FF, each even address gets 0x00 and each odd address gets 0xF8; busy high 512 clocks, then cmd_ready.
REQ-038 cmd_valid held high while busy during a write -> second command accepted only in IDLE, with no overlap of host strobes.
REQ-039 reset_n low at fill entry 100 -> host_wrena = 0 from the next clock, all outputs at reset values; a subsequent write completes normally.
REQ-040 cmd_op = 3 -> accepted, no host_wrena, no rsp_valid, back in IDLE next clock.
